// File: rtl/game_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : game_round_ctrl_if
// Purpose  : Signal bundle between the round sequencer and its neighbours
//            (authentication, pattern generator, timer, scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
interface game_round_ctrl_if;
    logic       authorised;
    logic       start_btn;
    logic [1:0] level;
    logic       sec_tick;
    logic       match;
    logic       gen_ack;
    logic       gen_req;
    logic       play_en;
    logic [3:0] time_left;
    logic       score_inc;
    logic       miss_pulse;
    logic [3:0] round_num;
    logic [1:0] misses;
    logic       game_over;
    logic [2:0] state;

    modport master (
        input  authorised, start_btn, level, sec_tick, match, gen_ack,
        output gen_req, play_en, time_left, score_inc, miss_pulse,
               round_num, misses, game_over, state
    );

    modport slave (
        output authorised, start_btn, level, sec_tick, match, gen_ack,
        input  gen_req, play_en, time_left, score_inc, miss_pulse,
               round_num, misses, game_over, state
    );
endinterface
`default_nettype wire

// File: rtl/game_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_round_ctrl
// Purpose  : Round sequencer: requests patterns, opens the play window, counts
//            round time and ends the game. GRC_BONUS_TIME_EN enables 2-point hits.
// Revision : 1.0 - initial release
// ============================================================================
module game_round_ctrl #(
    parameter int ROUND_SECS = 15,
    parameter int NUM_ROUNDS = 5,
    parameter int MAX_MISSES = 3
) (
    input  wire logic          clk,
    input  wire logic          rst,
    game_round_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT_GEN = 3'd2,
        ST_PLAY     = 3'd3,
        ST_HIT      = 3'd4,
        ST_MISS     = 3'd5,
        ST_OVER     = 3'd6
    } state_t;

    state_t     state_q,     state_d;
    logic [3:0] time_left_q, time_left_d;
    logic [3:0] round_num_q, round_num_d;
    logic [1:0] misses_q,    misses_d;
    logic [3:0] w_round_time;
    logic       w_hit_last;

    // Per-level round time, never below one second
    always_comb begin
        if (ROUND_SECS > 3 * int'(bus.level)) begin
            w_round_time = 4'(ROUND_SECS - 3 * int'(bus.level));
        end else begin
            w_round_time = 4'd1;
        end
    end

`ifdef GRC_BONUS_TIME_EN
    logic [3:0] round_time_q, round_time_d;
    logic       bonus_q,      bonus_d;

    always_comb begin
        round_time_d = round_time_q;
        bonus_d      = bonus_q;
        if (state_q == ST_WAIT_GEN && bus.gen_ack) begin
            round_time_d = w_round_time;
        end
        if (state_q == ST_PLAY && bus.match) begin
            bonus_d = ({time_left_q, 1'b0} >= {1'b0, round_time_q});
        end else if (state_q == ST_HIT || state_d == ST_IDLE) begin
            bonus_d = 1'b0;
        end
    end

    assign w_hit_last = !bonus_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            round_time_q <= 4'd0;
            bonus_q      <= 1'b0;
        end else begin
            round_time_q <= round_time_d;
            bonus_q      <= bonus_d;
        end
    end
`else
    assign w_hit_last = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        time_left_d = time_left_q;
        round_num_d = round_num_q;
        misses_d    = misses_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.authorised && bus.start_btn) state_d = ST_REQ;
            end
            ST_REQ: begin
                state_d = ST_WAIT_GEN;
            end
            ST_WAIT_GEN: begin
                if (bus.gen_ack) begin
                    state_d     = ST_PLAY;
                    time_left_d = w_round_time;
                end
            end
            ST_PLAY: begin
                if (bus.match) begin
                    state_d = ST_HIT;
                end else if (bus.sec_tick) begin
                    if (time_left_q > 4'd1) begin
                        time_left_d = time_left_q - 4'd1;
                    end else begin
                        time_left_d = 4'd0;
                        state_d     = ST_MISS;
                    end
                end
            end
            ST_HIT: begin
                if (w_hit_last) begin
                    round_num_d = (round_num_q == 4'd15) ? 4'd15 : round_num_q + 4'd1;
                    state_d     = (round_num_d == 4'(NUM_ROUNDS)) ? ST_OVER : ST_REQ;
                end
            end
            ST_MISS: begin
                round_num_d = (round_num_q == 4'd15) ? 4'd15 : round_num_q + 4'd1;
                misses_d    = (misses_q == 2'd3) ? 2'd3 : misses_q + 2'd1;
                if (misses_d == 2'(MAX_MISSES) || round_num_d == 4'(NUM_ROUNDS)) begin
                    state_d = ST_OVER;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_OVER: begin
                if (bus.start_btn) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Logout overrides everything; entering IDLE always starts from a clean slate
        if (state_q != ST_IDLE && !bus.authorised) state_d = ST_IDLE;
        if (state_d == ST_IDLE) begin
            time_left_d = 4'd0;
            round_num_d = 4'd0;
            misses_d    = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            time_left_q <= 4'd0;
            round_num_q <= 4'd0;
            misses_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            time_left_q <= time_left_d;
            round_num_q <= round_num_d;
            misses_q    <= misses_d;
        end
    end

    assign bus.gen_req    = (state_q == ST_REQ);
    assign bus.play_en    = (state_q == ST_PLAY);
    assign bus.score_inc  = (state_q == ST_HIT);
    assign bus.miss_pulse = (state_q == ST_MISS);
    assign bus.game_over  = (state_q == ST_OVER);
    assign bus.time_left  = time_left_q;
    assign bus.round_num  = round_num_q;
    assign bus.misses     = misses_q;
    assign bus.state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_game_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_round_ctrl
// Purpose  : Directed and randomized checks of game_round_ctrl against a
//            game-level reference model evaluated every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_round_ctrl;
    localparam int ROUND_SECS = 15;
    localparam int NUM_ROUNDS = 5;
    localparam int MAX_MISSES = 3;
`ifdef GRC_BONUS_TIME_EN
    localparam int BONUS = 1;
`else
    localparam int BONUS = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    game_round_ctrl_if bus ();

    game_round_ctrl #(
        .ROUND_SECS (ROUND_SECS),
        .NUM_ROUNDS (NUM_ROUNDS),
        .MAX_MISSES (MAX_MISSES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Game-level model: phase follows the published state codes
    int m_ph = 0, m_tl = 0, m_rounds = 0, m_misses = 0, m_rt = 0, m_score_left = 0;

    task automatic m_clear();
        m_ph = 0; m_tl = 0; m_rounds = 0; m_misses = 0; m_score_left = 0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("state",      int'(bus.state),      m_ph);
            chk("gen_req",    int'(bus.gen_req),    int'(m_ph == 1));
            chk("play_en",    int'(bus.play_en),    int'(m_ph == 3));
            chk("score_inc",  int'(bus.score_inc),  int'(m_ph == 4));
            chk("miss_pulse", int'(bus.miss_pulse), int'(m_ph == 5));
            chk("game_over",  int'(bus.game_over),  int'(m_ph == 6));
            chk("time_left",  int'(bus.time_left),  m_tl);
            chk("round_num",  int'(bus.round_num),  m_rounds);
            chk("misses",     int'(bus.misses),     m_misses);
            // Advance with the inputs the next rising edge will sample
            if (!rst) begin
                m_clear();
                m_rt = 0;
            end else if (m_ph != 0 && !bus.authorised) begin
                m_clear();
            end else begin
                case (m_ph)
                    0: if (bus.start_btn) m_ph = 1;
                    1: m_ph = 2;
                    2: if (bus.gen_ack) begin
                        m_rt = ROUND_SECS - 3 * int'(bus.level);
                        if (m_rt < 1) m_rt = 1;
                        m_tl = m_rt;
                        m_ph = 3;
                    end
                    3: if (bus.match) begin
                        m_score_left = (BONUS != 0 && m_tl * 2 >= m_rt) ? 2 : 1;
                        m_ph = 4;
                    end else if (bus.sec_tick) begin
                        m_tl = m_tl - 1;
                        if (m_tl == 0) m_ph = 5;
                    end
                    4: begin
                        m_score_left--;
                        if (m_score_left == 0) begin
                            m_rounds = (m_rounds < 15) ? m_rounds + 1 : 15;
                            m_ph = (m_rounds == NUM_ROUNDS) ? 6 : 1;
                        end
                    end
                    5: begin
                        m_rounds = (m_rounds < 15) ? m_rounds + 1 : 15;
                        m_misses = (m_misses < 3) ? m_misses + 1 : 3;
                        m_ph = (m_misses == MAX_MISSES || m_rounds == NUM_ROUNDS) ? 6 : 1;
                    end
                    6: if (bus.start_btn) m_clear();
                    default: m_clear();
                endcase
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_state(input int code, input int budget, input string nm);
        int n = 0;
        while (int'(bus.state) != code && n < budget) begin
            cyc(1);
            n++;
        end
        chk(nm, int'(bus.state), code);
    endtask

    task automatic pulse_start();
        bus.start_btn = 1'b1; cyc(1); bus.start_btn = 1'b0;
    endtask

    task automatic ack(input logic [1:0] lvl);
        bus.level = lvl; bus.gen_ack = 1'b1; cyc(1); bus.gen_ack = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.sec_tick = 1'b1; cyc(1); bus.sec_tick = 1'b0; cyc(1);
        end
    endtask

    initial begin
        bus.authorised = 1'b0; bus.start_btn = 1'b0; bus.level = 2'd0;
        bus.sec_tick = 1'b0;   bus.match = 1'b0;     bus.gen_ack = 1'b0;
        cyc(2);
        chk("lit_reset_state", int'(bus.state), 0);
        rst = 1'b1;
        cyc(1);

        // Start: gen_req one cycle after start_btn, exactly one cycle wide
        bus.authorised = 1'b1;
        pulse_start();
        chk("lit_gen_req_on", int'(bus.gen_req), 1);
        cyc(1);
        chk("lit_gen_req_off", int'(bus.gen_req), 0);

        // Level 2 -> 9 s, then timeout
        ack(2'd2);
        bus.level = 2'd0;
        chk("lit_time_l2", int'(bus.time_left), 9);
        for (int i = 0; i < 9; i++) begin
            bus.sec_tick = 1'b1; cyc(1); bus.sec_tick = 1'b0;
            if (i < 8) cyc(1);
        end
        chk("lit_miss_pulse", int'(bus.miss_pulse), 1);
        cyc(1);
        chk("lit_misses_1", int'(bus.misses), 1);
        chk("lit_gen_req_again", int'(bus.gen_req), 1);

        // Hit at 10 s left, coincident with a tick
        cyc(1);
        ack(2'd0);
        ticks(5);
        chk("lit_time_10", int'(bus.time_left), 10);
        bus.match = 1'b1; bus.sec_tick = 1'b1; cyc(1); bus.match = 1'b0; bus.sec_tick = 1'b0;
        chk("lit_hit_score", int'(bus.score_inc), 1);
        chk("lit_hit_no_dec", int'(bus.time_left), 10);
        cyc(1);
        chk("lit_bonus_2nd", int'(bus.score_inc), BONUS);
        wait_state(1, 4, "hit_to_req");
        chk("lit_rounds_2", int'(bus.round_num), 2);

        // Hit at 4 s left: never a bonus
        cyc(1);
        ack(2'd0);
        ticks(11);
        chk("lit_time_4", int'(bus.time_left), 4);
        bus.match = 1'b1; cyc(1); bus.match = 1'b0;
        chk("lit_hit4_score", int'(bus.score_inc), 1);
        cyc(1);
        chk("lit_hit4_single", int'(bus.score_inc), 0);
        wait_state(1, 4, "hit4_to_req");

        // Stray gen_ack in PLAY, then abort with 7 s left
        cyc(1);
        ack(2'd0);
        ticks(8);
        bus.gen_ack = 1'b1; cyc(1); bus.gen_ack = 1'b0;
        chk("lit_stray_ack_state", int'(bus.state), 3);
        chk("lit_time_7", int'(bus.time_left), 7);
        bus.authorised = 1'b0; cyc(1);
        chk("lit_abort_state", int'(bus.state), 0);
        chk("lit_abort_play_en", int'(bus.play_en), 0);
        chk("lit_abort_rounds", int'(bus.round_num), 0);
        chk("lit_abort_time", int'(bus.time_left), 0);
        bus.authorised = 1'b1; cyc(1);

        // Five hits end the game
        pulse_start();
        for (int r = 0; r < NUM_ROUNDS; r++) begin
            wait_state(2, 6, "hits_wait_gen");
            ack(2'($urandom_range(0, 3)));
            bus.match = 1'b1; cyc(1); bus.match = 1'b0;
        end
        wait_state(6, 6, "hits_over");
        chk("lit_over_rounds", int'(bus.round_num), 5);
        chk("lit_over_flag", int'(bus.game_over), 1);
        pulse_start();
        chk("lit_over_exit", int'(bus.state), 0);

        // Three timeouts end the game early
        pulse_start();
        for (int r = 0; r < MAX_MISSES; r++) begin
            wait_state(2, 6, "miss_wait_gen");
            ack(2'd3);
            ticks(6);
        end
        wait_state(6, 6, "miss_over");
        chk("lit_miss_over_misses", int'(bus.misses), 3);
        chk("lit_miss_over_rounds", int'(bus.round_num), 3);
        pulse_start();

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            rst            = ($urandom_range(0, 599) != 0);
            bus.authorised = ($urandom_range(0, 249) != 0);
            bus.start_btn  = ($urandom_range(0, 19) == 0);
            bus.level      = 2'($urandom_range(0, 3));
            bus.sec_tick   = ($urandom_range(0, 2) == 0);
            bus.match      = ($urandom_range(0, 14) == 0);
            bus.gen_ack    = ($urandom_range(0, 3) == 0);
            cyc(1);
        end
        rst = 1'b1; bus.start_btn = 1'b0; bus.sec_tick = 1'b0;
        bus.match = 1'b0; bus.gen_ack = 1'b0;
        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Round sequencer for the pattern-matching game.
- Once the player is authorised, it runs a fixed number of rounds. Each round it requests a new random pattern, opens the Load/Shift play window and counts down a per-level round time from the 1 s tick.
- It issues score/miss pulses to the scoreboard and ends the game on round count or miss limit.
- Sits between the authentication, random-pattern, timer and score blocks.

Parameters:
- ROUND_SECS, 15, base round time in seconds for level 0; legal 4..15.
- NUM_ROUNDS, 5, rounds per game; legal 1..15.
- MAX_MISSES, 3, misses that end the game early; legal 1..3.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- authorised  in  1  level; high while the user is logged in.
- start_btn  in  1  one-cycle shaped pulse; starts a game or leaves OVER.
- level  in  2  difficulty, sampled at round start.
- sec_tick  in  1  one-cycle pulse per second.
- match  in  1  one-cycle pulse; player value equals pattern.
- gen_ack  in  1  one-cycle pulse; pattern generator has a new pattern ready.
- gen_req  out  1  one-cycle pulse; request a new pattern.
- play_en  out  1  high while Load/Shift input is accepted.
- time_left  out  4  remaining seconds in the current round.
- score_inc  out  1  pulse to the scoreboard on a hit.
- miss_pulse  out  1  pulse on timeout miss.
- round_num  out  4  completed rounds in the current game.
- misses  out  2  misses in the current game.
- game_over  out  1  high in OVER.
- state  out  3  FSM state code, for debug.

Behaviour:
Reset and state encoding:
- rst low at a clk edge: state=IDLE; all outputs 0.
- States and codes: IDLE=0, REQ=1, WAIT_GEN=2, PLAY=3, HIT=4, MISS=5, OVER=6. Code 7 is illegal and goes to IDLE.

Abort:
- Highest priority: authorised low in any state other than IDLE sends the FSM to IDLE on the next edge.
- On abort: round_num, misses and time_left cleared; no score/miss pulse issued.

State transitions:
- IDLE: round_num=0, misses=0. authorised & start_btn -> REQ.
- REQ: gen_req=1 for exactly one cycle -> WAIT_GEN.
- WAIT_GEN: hold until gen_ack, then -> PLAY.
  - On that same edge, level is latched and time_left = ROUND_SECS - 3*level, floored at 1.
  - With default ROUND_SECS=15, levels 0..3 give 15, 12, 9, 6.
  - A gen_ack arriving outside WAIT_GEN is ignored.
- PLAY: play_en=1; level changes are ignored until the next round.
  - match -> HIT. match has priority over sec_tick in the same cycle; time_left is not decremented in that case.
  - sec_tick with time_left>1 -> decrement.
  - sec_tick with time_left==1 -> time_left=0 and -> MISS.
  - play_en drops on the edge that leaves PLAY.
- HIT: score_inc=1 for one cycle; round_num+1.
  - If the new round_num==NUM_ROUNDS -> OVER, else -> REQ.
- MISS: miss_pulse=1 for one cycle; misses+1 and round_num+1.
  - If the new misses==MAX_MISSES or the new round_num==NUM_ROUNDS -> OVER, else -> REQ.
- OVER: game_over=1; round_num and misses hold for display. start_btn -> IDLE.

Timing:
- Latency start_btn -> gen_req is 1 cycle.
- A second gen_req is never issued before the previous gen_ack.
- start_btn is ignored in REQ, WAIT_GEN, PLAY, HIT and MISS.
- Counters saturate and never wrap: round_num at 15, misses at 3.

Optional Feature:
GRC_BONUS_TIME_EN
- Defined: on HIT, if time_left at hit is at least half the latched round time (time_left*2 >= round time), score_inc is high for two consecutive cycles, i.e. HIT lasts 2 cycles and the scoreboard counts 2 points. Otherwise score_inc is a single pulse.
- Undefined: score_inc is always a single one-cycle pulse and HIT lasts 1 cycle.

Test Plan:
- Reset/start: rst low 2 cycles, then authorised=1 and start_btn pulse -> gen_req high exactly 1 cycle, on the edge after start_btn; all other outputs 0.
- Level timing: level=2, gen_ack -> time_left=9, play_en=1; 9 sec_ticks -> miss_pulse once, misses=1, gen_req reissued 1 cycle later.
- Hit path: match in PLAY -> score_inc one cycle, round_num+1. match coincident with sec_tick -> HIT taken, no decrement.
- Game end: 5 hits -> game_over=1, round_num=5. 3 consecutive timeouts -> game_over with misses=3, round_num=3.
- Abort: authorised dropped mid-PLAY with time_left=7 -> IDLE next cycle, play_en=0, round_num=0, no pulses. Stray gen_ack in PLAY is ignored.
- GRC_BONUS_TIME_EN: level 0, match at time_left=10 -> score_inc 2 cycles; match at time_left=4 -> 1 cycle. Without the macro -> 1 cycle in both cases.
